// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port, with a stall watchdog.
// Latency: one arbitration cycle from a master's cyc to s_cyc_o; data/ack paths are combinational.
// Backpressure: losing masters wait with cyc held; the grant persists for the whole cyc frame.
module wb_master_arbiter #(
    parameter int NM      = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [DW-1:0]        s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    output logic [NM-1:0]        grant_o,
    output logic                 timeout_o
);
    localparam int SW = DW / 8;
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state;
    logic [NM-1:0]   r_grant;
    logic [IW-1:0]   r_gidx;
    logic [IW-1:0]   r_last;
    logic [WW-1:0]   r_wdog;

    logic            w_found;
    logic [IW:0]     w_sum;
    logic [IW-1:0]   w_pick;
    logic [NM-1:0]   w_pick_oh;
    logic            w_cyc;
    logic            w_stb;
    logic            w_expire;

    // Search last+1, last+2, ... modulo NM; the first requester wins.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = '0;
        w_sum     = '0;
        w_pick_oh = '0;
        for (int i = 1; i <= NM; i++) begin
            w_sum = {1'b0, r_last} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(NM))
                w_sum = w_sum - (IW+1)'(NM);
            if (!w_found && m_cyc_i[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IW-1:0];
            end
        end
        for (int k = 0; k < NM; k++)
            w_pick_oh[k] = w_found && (w_pick == IW'(k));
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        if (r_state == BUSY) begin
            for (int k = 0; k < NM; k++) begin
                if (r_gidx == IW'(k)) begin
                    s_adr_o = m_adr_i[k*AW +: AW];
                    s_dat_o = m_dat_i[k*DW +: DW];
                    s_sel_o = m_sel_i[k*SW +: SW];
                    s_we_o  = m_we_i[k];
                    w_cyc   = m_cyc_i[k];
                    w_stb   = m_stb_i[k];
                end
            end
        end
        w_expire  = (TIMEOUT != 0) && w_stb && (r_wdog == WW'(TIMEOUT));
        s_cyc_o   = w_cyc;
        s_stb_o   = w_stb && !w_expire;
        timeout_o = w_expire;
        m_ack_o   = r_grant & {NM{s_ack_i}};
        m_err_o   = r_grant & {NM{s_err_i | w_expire}};
        m_dat_o   = (r_state == BUSY) ? s_dat_i : '0;
    end

    assign grant_o = r_grant;

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= IW'(NM - 1);
            r_wdog  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wdog <= '0;
                    if (w_found) begin
                        r_grant <= w_pick_oh;
                        r_gidx  <= w_pick;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_cyc) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_last  <= r_gidx;
                        r_wdog  <= '0;
                    end else if (TIMEOUT == 0 || w_expire || !w_stb || s_ack_i || s_err_i) begin
                        r_wdog <= '0;
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: reset, round robin, routing, burst hold, watchdog, mid-frame reset.
// Latency: inputs are driven 1ns after each rising edge and outputs sampled 2ns after it.
// Backpressure: the slave side is modelled by hand-driven s_ack_i / s_err_i.
module tb_wb_master_arbiter;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               nrst;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*DW-1:0]   m_dat;
    logic [NM*DW/8-1:0] m_sel;
    logic [NM-1:0]      m_we, m_cyc, m_stb;
    logic [DW-1:0]      m_dat_o;
    logic [NM-1:0]      m_ack, m_err;
    logic [AW-1:0]      s_adr;
    logic [DW-1:0]      s_dat_o;
    logic [DW/8-1:0]    s_sel;
    logic               s_we, s_cyc, s_stb;
    logic [DW-1:0]      s_dat_i;
    logic               s_ack, s_err;
    logic [NM-1:0]      grant;
    logic               tmo;

    int n_cmp = 0;
    int n_err = 0;

    wb_master_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk_i(clk), .nrst_i(nrst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change at +1ns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        nrst = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
        m_cyc = '0; m_stb = '0; s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;

        // 1: reset with every master requesting and the slave asserting ack/err
        m_cyc = 3'b111; m_stb = 3'b111; s_ack = 1'b1; s_err = 1'b1;
        repeat (3) tick();
        settle();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_scyc", 64'(s_cyc), 64'd0);
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_err", 64'(m_err), 64'd0);
        chk("rst_tmo", 64'(tmo), 64'd0);
        s_ack = 1'b0; s_err = 1'b0;
        nrst = 1'b1;
        tick(); settle();
        chk("first_grant", 64'(grant), 64'b001);
        chk("first_scyc", 64'(s_cyc), 64'd1);

        // 2: round robin, each master releases in the same cycle as its ack
        for (int i = 0; i < 3; i++) begin
            s_ack = 1'b1; m_cyc[i] = 1'b0;
            settle();
            chk($sformatf("rr_ack%0d", i), 64'(m_ack), 64'(3'b001 << i));
            tick();
            s_ack = 1'b0; m_cyc[i] = 1'b1;
            settle();
            chk($sformatf("rr_idle%0d", i), 64'(grant), 64'd0);
            chk($sformatf("rr_idle_scyc%0d", i), 64'(s_cyc), 64'd0);
            tick(); settle();
            chk($sformatf("rr_grant%0d", i), 64'(grant), 64'(3'b001 << ((i + 1) % 3)));
        end
        m_cyc = '0; m_stb = '0;
        tick(); tick();

        // 3: master 2 write, routed one cycle after cyc
        m_adr[2*AW +: AW] = 32'h2000_0010;
        m_dat[2*DW +: DW] = 32'hDEAD_BEEF;
        m_sel[2*4 +: 4]   = 4'hF;
        m_we[2] = 1'b1; m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        settle();
        chk("wr_arb_scyc", 64'(s_cyc), 64'd0);
        tick(); settle();
        chk("wr_grant", 64'(grant), 64'b100);
        chk("wr_scyc", 64'(s_cyc), 64'd1);
        chk("wr_sstb", 64'(s_stb), 64'd1);
        chk("wr_adr", 64'(s_adr), 64'h2000_0010);
        chk("wr_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
        chk("wr_sel", 64'(s_sel), 64'hF);
        chk("wr_we", 64'(s_we), 64'd1);
        s_ack = 1'b1; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        settle();
        chk("wr_ack", 64'(m_ack), 64'b100);
        tick();
        s_ack = 1'b0; m_we = '0;
        tick();

        // 4: master 0 burst of 4 reads while master 1 waits
        m_cyc = 3'b011; m_stb = 3'b001;
        tick(); settle();
        chk("burst_grant", 64'(grant), 64'b001);
        for (int b = 0; b < 4; b++) begin
            s_ack = 1'b1; s_dat_i = 32'hA5A5_0000 + 32'(b);
            settle();
            chk($sformatf("burst_ack%0d", b), 64'(m_ack), 64'b001);
            chk($sformatf("burst_rdat%0d", b), 64'(m_dat_o), 64'hA5A5_0000 + 64'(b));
            tick();
            s_ack = 1'b0;
            settle();
            chk($sformatf("burst_hold%0d", b), 64'(grant), 64'b001);
        end
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick(); settle();
        chk("burst_idle", 64'(grant), 64'd0);
        tick(); settle();
        chk("burst_next", 64'(grant), 64'b010);
        m_cyc = '0;
        tick(); tick();

        // 5: watchdog with TIMEOUT=4, slave silent
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick(); settle();
        chk("tmo_grant", 64'(grant), 64'b001);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("tmo_stb%0d", c), 64'(s_stb), 64'd1);
            chk($sformatf("tmo_pulse%0d", c), 64'({tmo, m_err}), 64'd0);
            tick(); settle();
        end
        chk("tmo_err", 64'(m_err), 64'b001);
        chk("tmo_pulse", 64'(tmo), 64'd1);
        chk("tmo_stb_forced", 64'(s_stb), 64'd0);
        tick(); settle();
        chk("tmo_after_pulse", 64'({tmo, m_err}), 64'd0);
        chk("tmo_after_stb", 64'(s_stb), 64'd1);
        chk("tmo_still_owned", 64'(grant), 64'b001);
        m_cyc = '0; m_stb = '0;
        tick(); tick();

        // 6: reset during a master 1 read; master 0 also waiting
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick(); settle();
        chk("mid_grant", 64'(grant), 64'b010);
        m_cyc[0] = 1'b1;
        nrst = 1'b0;
        tick();
        s_ack = 1'b1;
        settle();
        chk("mid_rst_grant", 64'(grant), 64'd0);
        chk("mid_rst_ack", 64'(m_ack), 64'd0);
        s_ack = 1'b0;
        nrst = 1'b1;
        tick(); settle();
        chk("mid_restart", 64'(grant), 64'b001);
        m_cyc = '0; m_stb = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
